// File: rtl/nn_fixed_pkg.sv
// nn_fixed_pkg: shared Q7.8 fixed-point constants and FSM state type for the neuron datapath.
package nn_fixed_pkg;
    localparam int DATA_W    = 16;
    localparam int FRAC_W    = 8;
    localparam int ACC_W     = 24;
    localparam int MAX_TERMS = 256;
    localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/sat_q78.sv
// sat_q78: combinational clamp of a wide signed accumulator to Q7.8 with an overflow flag.
module sat_q78
    import nn_fixed_pkg::*;
(
    input  logic [ACC_W-1:0]  i_acc,
    output logic [DATA_W-1:0] o_sat,
    output logic              o_ovf
);
    // The value fits iff every bit above the Q7.8 sign bit copies it.
    logic [ACC_W-DATA_W:0] w_top;
    assign w_top = i_acc[ACC_W-1:DATA_W-1];
    assign o_ovf = |w_top && !(&w_top);
    assign o_sat = o_ovf ? (i_acc[ACC_W-1] ? Q_MIN : Q_MAX) : i_acc[DATA_W-1:0];
endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: accumulates num_terms signed Q7.8 products onto a bias, emits a saturated result.
// Define MAC_RELU_EN to force negative results to zero after saturation.
module mac_accumulator
    import nn_fixed_pkg::*;
#(
    parameter int CNT_W = 9
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_terms,
    input  logic [DATA_W-1:0] bias_in,
    input  logic [DATA_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic [DATA_W-1:0] acc_out,
    output logic              out_valid,
    output logic              busy,
    output logic              ovf
);
    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  w_sat;
    logic [DATA_W-1:0]  w_res;
    logic               w_ovf;
    logic [ACC_W-1:0]   w_bias_ext;
    logic [ACC_W-1:0]   w_prod_ext;

    assign w_bias_ext = {{(ACC_W-DATA_W){bias_in[DATA_W-1]}}, bias_in};
    assign w_prod_ext = {{(ACC_W-DATA_W){prod_in[DATA_W-1]}}, prod_in};
    assign busy       = r_state != IDLE;

    sat_q78 u_sat (
        .i_acc (r_acc),
        .o_sat (w_sat),
        .o_ovf (w_ovf)
    );

`ifdef MAC_RELU_EN
    assign w_res = w_sat[DATA_W-1] ? '0 : w_sat;
`else
    assign w_res = w_sat;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            acc_out   <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_acc   <= w_bias_ext;
                    r_cnt   <= num_terms;
                    r_state <= (num_terms == '0) ? DONE : ACCUM;
                end
                ACCUM: if (prod_valid) begin
                    r_acc <= r_acc + w_prod_ext;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1))
                        r_state <= DONE;
                end
                DONE: begin
                    acc_out   <= w_res;
                    ovf       <= w_ovf;
                    out_valid <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: scoreboard bench for mac_accumulator.
module tb_mac_accumulator;
    import nn_fixed_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        prod_valid = 1'b0;
    logic [8:0]  num_terms = '0;
    logic [15:0] bias_in = '0;
    logic [15:0] prod_in = '0;
    logic [15:0] acc_out;
    logic        out_valid;
    logic        busy;
    logic        ovf;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    int jobs = 0;
    int p0;
    logic [16:0] exp_q[$];
    logic [15:0] prods[$];

    always #5 clk = ~clk;

    mac_accumulator #(.CNT_W(9)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_terms  (num_terms),
        .bias_in    (bias_in),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .acc_out    (acc_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .ovf        (ovf)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [15:0] bias, input int n);
        int s;
        logic [15:0] r;
        logic o;
        s = int'($signed(bias));
        for (int i = 0; i < n; i++) s += int'($signed(prods[i]));
        o = (s > 32767) || (s < -32768);
        r = (s > 32767) ? 16'h7FFF : (s < -32768) ? 16'h8000 : 16'(s);
`ifdef MAC_RELU_EN
        if (r[15]) r = 16'h0000;
`endif
        return {o, r};
    endfunction

    task automatic fill(input int n, input logic [15:0] v, input bit rnd);
        prods.delete();
        for (int i = 0; i < n; i++) prods.push_back(rnd ? 16'($urandom) : v);
    endtask

    // Caller is positioned at a negedge; returns at the negedge where out_valid must be high.
    task automatic run_job(input int n, input logic [15:0] bias, input int max_gap);
        assert (n <= MAX_TERMS) else $error("num_terms %0d exceeds MAX_TERMS", n);
        exp_q.push_back(model(bias, n));
        jobs++;
        start = 1'b1; num_terms = 9'(n); bias_in = bias;
        prod_valid = 1'b1; prod_in = 16'($urandom);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(max_gap, 0)) begin
                prod_valid = 1'b0; start = 1'b1; num_terms = 9'd5; bias_in = 16'h1234;
                prod_in = 16'($urandom);
                @(negedge clk);
            end
            start = 1'b0; prod_valid = 1'b1; prod_in = prods[i];
            @(negedge clk);
        end
        start = 1'b0; prod_valid = 1'b1; prod_in = 16'($urandom);
        check("done_cycle", {busy, out_valid}, 2'b10);
        @(negedge clk);
        prod_valid = 1'b0;
        check("out_valid_latency", {busy, out_valid}, 2'b01);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            pulses++;
            if (exp_q.size() == 0) check("unexpected_out_valid", 32'(out_valid), 32'd0);
            else check("result", {ovf, acc_out}, exp_q.pop_front());
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outputs", {busy, out_valid, ovf, acc_out}, 19'h0);
        rst_n = 1'b1;
        @(negedge clk);

        prods = '{16'h0100, 16'h0200, 16'hFF00};
        run_job(3, 16'h0000, 2);
        check("small_sum", {ovf, acc_out}, 17'h00200);

        fill(200, 16'h7FFF, 1'b0);
        @(negedge clk);
        run_job(200, 16'h0000, 0);
        check("sat_pos", {ovf, acc_out}, 17'h17FFF);

        fill(200, 16'h8000, 1'b0);
        @(negedge clk);
        run_job(200, 16'h0000, 0);
        check("sat_neg", {ovf, acc_out}, 17'h18000);

        prods.delete();
        @(negedge clk);
        run_job(0, 16'h0080, 0);
        check("zero_terms", {ovf, acc_out}, 17'h00080);

        fill(4, 16'h0, 1'b1);
        @(negedge clk);
        start = 1'b1; num_terms = 9'd4; bias_in = 16'h0111; prod_valid = 1'b1; prod_in = 16'h7777;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            prod_in = prods[i];
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("mid_job_reset", {busy, out_valid, ovf, acc_out}, 19'h0);
        @(negedge clk);
        rst_n = 1'b1; prod_valid = 1'b0;
        p0 = pulses;
        repeat (6) @(negedge clk);
        check("no_valid_after_reset", 32'(pulses), 32'(p0));
        run_job(4, 16'h0111, 1);

        fill(5, 16'h0, 1'b1);
        @(negedge clk);
        run_job(5, 16'($urandom), 1);
        fill(3, 16'h0, 1'b1);
        run_job(3, 16'($urandom), 0);

        for (int k = 0; k < 4; k++) begin
            fill(k == 3 ? MAX_TERMS : int'($urandom_range(16, 1)), 16'h0, 1'b1);
            @(negedge clk);
            run_job(prods.size(), 16'($urandom), k % 2);
        end

        prods = '{16'hFE00};
        @(negedge clk);
        run_job(1, 16'h0000, 0);
`ifdef MAC_RELU_EN
        check("relu_neg", {ovf, acc_out}, 17'h00000);
`else
        check("relu_neg", {ovf, acc_out}, 17'h0FE00);
`endif

        repeat (3) @(negedge clk);
        check("pulse_count", 32'(pulses), 32'(jobs));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
